// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
//
// Purpose: FSM and classification enums, matrix geometry, key legend and
//          auto-repeat timing shared by keypad_col_sequencer and keypad_scanner.
// Ports:   none (package).
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // Auto-repeat timing in full scans: first repeat delay, then repeat period.
  localparam int TYPEMATIC_DELAY = 16;
  localparam int TYPEMATIC_RATE  = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} class_t;

  // Indexed row*NUM_COLS + col; value is the hex code printed on the key.
  localparam logic [3:0] KEY_LEGEND [NUM_ROWS*NUM_COLS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_col_sequencer.sv
// rtl/keypad_col_sequencer.sv - column dwell divider and one-hot active-low column rotation
//
// Purpose: holds each column for SCAN_DIV cycles, strobes the sample point on
//          the last cycle of the dwell and flags the column 3 -> 0 wrap.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   col           out  [3:0] column drive, one-hot active-low
//   col_idx       out  [1:0] index of the driven column
//   sample        out  last cycle of the current column's dwell
//   scan_complete out  sample of column 3 (end of a full scan)
module keypad_col_sequencer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       scan_complete
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      col_idx <= '0;
    end else if (sample) begin
      div_q   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  assign sample        = (div_q == DIV_LAST);
  assign scan_complete = sample && (col_idx == 2'(NUM_COLS - 1));
  assign col           = ~(4'b0001 << col_idx);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and key strobe
//
// Purpose: scans the keypad columns, builds a 16-bit key map, classifies it
//          once per full scan and debounces a single key press/release.
// Optional: define KEYPAD_TYPEMATIC_EN to re-pulse KeyValid while a key is held.
// Ports:
//   CLK       in   system clock
//   RST       in   asynchronous active-low reset
//   Row       in   [3:0] keypad rows, active-low, asynchronous
//   Col       out  [3:0] keypad column drive, one-hot active-low
//   Key       out  [DWL-5:0] last accepted key code
//   KeyValid  out  one-cycle pulse when a key is accepted
//   KeyHeld   out  high while the accepted key remains pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWL            = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     Row,
  output logic [3:0]     Col,
  output logic [DWL-5:0] Key,
  output logic           KeyValid,
  output logic           KeyHeld
);

  localparam int               KW       = DWL - 4;
  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_SCANS);

  logic [1:0]  col_idx;
  logic        sample, scan_complete;
  logic [3:0]  row_meta, row_sync;
  logic [15:0] map_q, map_now;   // bit col*4+row, 1 = pressed
  logic [4:0]  n_pressed;
  logic [3:0]  code;
  class_t      cls;

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d, key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_d;

  keypad_col_sequencer #(.SCAN_DIV(SCAN_DIV)) u_seq (
    .clk           (CLK),
    .rst_n         (RST),
    .col           (Col),
    .col_idx       (col_idx),
    .sample        (sample),
    .scan_complete (scan_complete)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      map_q    <= '0;
    end else begin
      row_meta <= Row;
      row_sync <= row_meta;
      map_q    <= map_now;
    end
  end

  // Column 3 is sampled in the same cycle the scan completes, so the
  // classifier looks at the map including the sample being taken now.
  always_comb begin
    map_now = map_q;
    if (sample) map_now[{col_idx, 2'b00} +: 4] = ~row_sync;
  end

  always_comb begin
    n_pressed = '0;
    code      = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (map_now[c*NUM_ROWS + r]) begin
          n_pressed = n_pressed + 5'd1;
          code      = KEY_LEGEND[r*NUM_COLS + c];
        end
      end
    end
    if (n_pressed == 5'd0)      cls = NONE;
    else if (n_pressed == 5'd1) cls = SINGLE;
    else                        cls = MULTI;
  end

`ifdef KEYPAD_TYPEMATIC_EN
  logic [4:0] rep_q, rep_d;
  logic       fast_q, fast_d;   // first repeat already issued

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rep_q  <= '0;
      fast_q <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      fast_q <= fast_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      key_q    <= '0;
      KeyValid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      KeyValid <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
    rep_d   = rep_q;
    fast_d  = fast_q;
`endif
    if (scan_complete) begin
      case (state_q)
        IDLE: begin
          if (cls == SINGLE) begin
            cand_d = code;
            cnt_d  = CNT_W'(1);
            // A one-scan debounce accepts in this same evaluation.
            if (cnt_d >= DB_LIMIT) begin
              state_d = PRESSED;
              key_d   = code;
              valid_d = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
              rep_d   = '0;
              fast_d  = 1'b0;
`endif
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (cls == SINGLE && code == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d >= DB_LIMIT) begin
              state_d = PRESSED;
              key_d   = cand_q;
              valid_d = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
              rep_d   = '0;
              fast_d  = 1'b0;
`endif
            end
          end else if (cls == SINGLE) begin
            cand_d = code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (cls == NONE) begin
            cnt_d   = CNT_W'(1);
            state_d = (cnt_d >= DB_LIMIT) ? IDLE : RELEASE;
          end
`ifdef KEYPAD_TYPEMATIC_EN
          else if (cls == SINGLE && code == key_q) begin
            rep_d = rep_q + 5'd1;
            if (rep_d == (fast_q ? 5'(TYPEMATIC_RATE) : 5'(TYPEMATIC_DELAY))) begin
              valid_d = 1'b1;
              rep_d   = '0;
              fast_d  = 1'b1;
            end
          end
`endif
        end
        RELEASE: begin
          if (cls == NONE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d >= DB_LIMIT) state_d = IDLE;
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Key     = KW'(key_q);
  assign KeyHeld = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
//
// Purpose: models the keypad matrix around the DUT and checks reset state,
//          column rotation, debounce, ghosting, hold/second key, mid-scan
//          reset and (with KEYPAD_TYPEMATIC_EN) auto-repeat.
// Ports:   none (top-level bench).
module tb_keypad_scanner;

  localparam int DWL            = 8;
  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN_CYC       = 4 * SCAN_DIV;
`ifdef KEYPAD_TYPEMATIC_EN
  localparam int EXP_E_PULSES = 5;
`else
  localparam int EXP_E_PULSES = 1;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [3:0]     Row;
  logic [3:0]     Col;
  logic [DWL-5:0] Key;
  logic           KeyValid;
  logic           KeyHeld;

  logic [15:0] keys = '0;   // pressed switches, bit row*4+col
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          consec = 0;
  int          base;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_col [4];

  keypad_scanner #(
    .DWL            (DWL),
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Row      (Row),
    .Col      (Col),
    .Key      (Key),
    .KeyValid (KeyValid),
    .KeyHeld  (KeyHeld)
  );

  always #5 CLK = ~CLK;

  // A row reads low when any pressed switch on it sits on a driven column.
  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++) Row[r] = ~|(keys[r*4 +: 4] & ~Col);
  end

  always @(negedge CLK) begin
    if (!RST) begin
      prev_valid <= 1'b0;
    end else begin
      if (KeyValid) begin
        pulses <= pulses + 1;
        if (prev_valid) consec <= consec + 1;
      end
      prev_valid <= KeyValid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN_CYC) @(negedge CLK);
    #1;
  endtask

  initial begin
    exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_col", 32'(Col), 32'h0E);
    check("rst_key", 32'(Key), 32'h0);
    check("rst_valid", 32'(KeyValid), 32'h0);
    check("rst_held", 32'(KeyHeld), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      repeat (SCAN_DIV) @(negedge CLK);
      #1;
      check("col_rotate", 32'(Col), 32'(exp_col[i]));
    end

    // Key "3": row 0, column 2
    keys = 16'h0004;
    wait_scans(3);
    check("k3_pulses", 32'(pulses), 32'd1);
    check("k3_key", 32'(Key), 32'h3);
    check("k3_held", 32'(KeyHeld), 32'h1);
    keys = '0;
    wait_scans(2);
    check("k3_release_held", 32'(KeyHeld), 32'h0);
    check("k3_release_pulses", 32'(pulses), 32'd1);

    // Key "5" bouncing on alternate scans, then stable
    for (int i = 0; i < 3; i++) begin
      keys = 16'h0020;
      wait_scans(1);
      keys = '0;
      wait_scans(1);
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    keys = 16'h0020;
    wait_scans(2);
    check("k5_pulses", 32'(pulses), 32'd2);
    check("k5_key", 32'(Key), 32'h5);
    keys = '0;
    wait_scans(2);
    check("k5_release_held", 32'(KeyHeld), 32'h0);

    // Ghost: "1" and "6" together
    keys = 16'h0041;
    wait_scans(3);
    check("ghost_pulses", 32'(pulses), 32'd2);
    check("ghost_key", 32'(Key), 32'h5);
    keys = '0;
    wait_scans(1);

    // "A" held, "D" added, "A" released with "D" still down
    keys = 16'h0008;
    wait_scans(2);
    check("kA_pulses", 32'(pulses), 32'd3);
    check("kA_key", 32'(Key), 32'hA);
    keys = 16'h8008;
    wait_scans(2);
    check("kAD_pulses", 32'(pulses), 32'd3);
    keys = 16'h8000;
    wait_scans(2);
    check("kD_only_pulses", 32'(pulses), 32'd3);
    check("kD_only_key", 32'(Key), 32'hA);
    check("kD_only_held", 32'(KeyHeld), 32'h1);
    keys = '0;
    wait_scans(2);
    check("kAD_release_held", 32'(KeyHeld), 32'h0);
    keys = 16'h8000;
    wait_scans(2);
    check("kD_pulses", 32'(pulses), 32'd4);
    check("kD_key", 32'(Key), 32'hD);
    keys = '0;
    wait_scans(2);

    // Key "7" seen one scan, then reset mid-scan
    keys = 16'h0100;
    wait_scans(1);
    repeat (5) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_col", 32'(Col), 32'h0E);
    check("mid_rst_key", 32'(Key), 32'h0);
    check("mid_rst_valid", 32'(KeyValid), 32'h0);
    check("mid_rst_held", 32'(KeyHeld), 32'h0);
    repeat (2) @(negedge CLK);
    keys = '0;
    RST = 1'b1;
    #1;
    check("mid_rst_release_col", 32'(Col), 32'h0E);
    wait_scans(2);
    check("mid_rst_pulses", 32'(pulses), 32'd4);

    // Key "E" held for 30 scans
    base = pulses;
    keys = 16'h4000;
    wait_scans(30);
    check("kE_pulses", 32'(pulses - base), 32'(EXP_E_PULSES));
    check("kE_key", 32'(Key), 32'hE);
    keys = '0;
    wait_scans(2);
    check("kE_release_held", 32'(KeyHeld), 32'h0);

    check("valid_width", 32'(consec), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
